conv_window_sequencer: RTL and testbench

//  Sequences one frame through the 3x3-window image buffer and the filter pipeline.

---
 rtl/conv_window_sequencer.sv | 152 +++++++++++++++
 tb/tb_conv_window_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// Raster-scan sequencer for 3x3 window filtering: issues one window read per cycle
// and delays each window's coordinates so the result write lines up with the filter.
module conv_window_sequencer #(
   parameter int IMG_W    = 64,
   parameter int IMG_H    = 64,
   parameter int PIPE_LAT = 2,
   parameter int AW       = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stall,
   output logic          rd,
   output logic [AW-1:0] rd_row,
   output logic [AW-1:0] rd_col,
   output logic          wr,
   output logic [AW-1:0] wr_row,
   output logic [AW-1:0] wr_col,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [AW-1:0]       LAST_COL  = AW'(IMG_W - 1);
   localparam logic [AW-1:0]       LAST_ROW  = AW'(IMG_H - 1);
   localparam logic [PIPE_LAT-1:0] TOP_STAGE = PIPE_LAT'(1) << (PIPE_LAT - 1);

   state_t              state_reg;
   logic [AW-1:0]       row_reg;
   logic [AW-1:0]       col_reg;
   logic                busy_reg;
   logic                done_reg;

   logic [PIPE_LAT-1:0] sh_valid;
   logic [AW-1:0]       sh_row [PIPE_LAT];
   logic [AW-1:0]       sh_col [PIPE_LAT];

   logic                last_col;
   logic                last_row;
   logic                drain_empty;

   assign rd       = (state_reg == RUN) && !stall;
   assign last_col = (col_reg == LAST_COL);
   assign last_row = (row_reg == LAST_ROW);

   // In DRAIN nothing enters stage 0, so after one more shift only the last stage's
   // content would remain; it leaves on that same edge, so the pipe is then empty.
   assign drain_empty = ((sh_valid & ~TOP_STAGE) == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         row_reg   <= '0;
         col_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg <= RUN;
                  busy_reg  <= 1'b1;
               end
            end
            RUN: begin
               if (!stall) begin
                  if (last_col) begin
                     col_reg <= '0;
                     if (last_row) begin
                        row_reg   <= '0;
                        state_reg <= DRAIN;
                     end else begin
                        row_reg <= row_reg + AW'(1);
                     end
                  end else begin
                     col_reg <= col_reg + AW'(1);
                  end
               end
            end
            DRAIN: begin
               if (!stall && drain_empty) begin
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Shadow pipeline: each stage carries {valid,row,col} of one issued window.
   genvar gi;
   generate
      for (gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
         logic          v_in;
         logic [AW-1:0] r_in;
         logic [AW-1:0] c_in;
         logic          v_reg;
         logic [AW-1:0] r_reg;
         logic [AW-1:0] c_reg;

         if (gi == 0) begin : g_head
            assign v_in = rd;
            assign r_in = row_reg;
            assign c_in = col_reg;
         end else begin : g_tail
            assign v_in = sh_valid[gi-1];
            assign r_in = sh_row[gi-1];
            assign c_in = sh_col[gi-1];
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_reg <= 1'b0;
               r_reg <= '0;
               c_reg <= '0;
            end else if (!stall) begin
               v_reg <= v_in;
               r_reg <= r_in;
               c_reg <= c_in;
            end
         end

         assign sh_valid[gi] = v_reg;
         assign sh_row[gi]   = r_reg;
         assign sh_col[gi]   = c_reg;
      end
   endgenerate

   assign wr     = sh_valid[PIPE_LAT-1] && !stall;
   assign wr_row = sh_row[PIPE_LAT-1];
   assign wr_col = sh_col[PIPE_LAT-1];
   assign rd_row = row_reg;
   assign rd_col = col_reg;
   assign busy   = busy_reg;
   assign done   = done_reg;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: a frame-level model based on
// "effective time" (unstalled busy cycles) predicts every cycle's rd/wr/busy/done.
module tb_conv_window_sequencer;

   localparam int IMG_W = 64;
   localparam int IMG_H = 64;
   localparam int PL    = 2;
   localparam int AW    = 7;
   localparam int N     = IMG_W * IMG_H;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          stall;
   logic          rd;
   logic [AW-1:0] rd_row;
   logic [AW-1:0] rd_col;
   logic          wr;
   logic [AW-1:0] wr_row;
   logic [AW-1:0] wr_col;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: phase 0=idle 1=busy 2=done; m_e counts unstalled busy cycles so far.
   int            m_phase = 0;
   int            m_e     = 0;
   logic          exp_rd, exp_wr, exp_busy, exp_done;
   logic [AW-1:0] exp_rr, exp_rc, exp_wrr, exp_wrc;

   conv_window_sequencer #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .PIPE_LAT(PL), .AW(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .rd(rd), .rd_row(rd_row), .rd_col(rd_col),
      .wr(wr), .wr_row(wr_row), .wr_col(wr_col),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle, computes this cycle's expected outputs, advances the model
   // across the closing edge, and returns at the negedge for sampling.
   task automatic drive_cycle(input logic st, input logic sl, input logic rn);
      int k;
      @(posedge clk);
      #1;
      start = st;
      stall = sl;
      rst_n = rn;
      exp_rd = 0; exp_wr = 0; exp_busy = 0; exp_done = 0;
      exp_rr = '0; exp_rc = '0; exp_wrr = '0; exp_wrc = '0;
      if (m_phase == 1) begin
         exp_busy = 1;
         if (!sl) begin
            k = m_e;
            if (k < N) begin
               exp_rd = 1;
               exp_rr = AW'(k / IMG_W);
               exp_rc = AW'(k % IMG_W);
            end
            if (k >= PL && k - PL < N) begin
               exp_wr  = 1;
               exp_wrr = AW'((k - PL) / IMG_W);
               exp_wrc = AW'((k - PL) % IMG_W);
            end
         end
      end else if (m_phase == 2) begin
         exp_done = 1;
      end
      if (!rn) begin
         m_phase = 0;
         m_e     = 0;
      end else if (m_phase == 0) begin
         if (st) begin
            m_phase = 1;
            m_e     = 0;
         end
      end else if (m_phase == 1) begin
         if (!sl) begin
            m_e++;
            if (m_e == N + PL) m_phase = 2;
         end
      end else begin
         m_phase = 0;
      end
      @(negedge clk);
   endtask

   // Runs one frame from a start pulse in cycle 0, comparing every cycle to the model.
   task automatic run_frame(input int stall_e, input int stall_len, input int rnd_pct,
                            input bit restart, input int abort_at,
                            output int done_cyc, output int rd_cnt, output int wr_cnt);
      int c, stalls, tail;
      logic st, sl, rn;
      logic [4*AW+3:0] obs, expv;
      done_cyc = -1; rd_cnt = 0; wr_cnt = 0; stalls = 0; tail = 0;
      for (c = 0; c < 3 * N; c++) begin
         st = (c == 0) || (restart && (c == 100 || m_phase == 2)) ||
              (rnd_pct > 0 && m_phase != 0 && $urandom_range(0, 19) == 0);
         sl = 1'b0;
         if (m_phase == 1 && m_e == stall_e && stalls < stall_len) begin
            sl = 1'b1;
            stalls++;
         end else if (rnd_pct > 0 && $urandom_range(0, 99) < rnd_pct) begin
            sl = 1'b1;
         end
         rn = (c != abort_at);
         drive_cycle(st, sl, rn);
         obs  = {rd, rd ? rd_row : '0, rd ? rd_col : '0,
                 wr, wr ? wr_row : '0, wr ? wr_col : '0, busy, done};
         expv = {exp_rd, exp_rr, exp_rc, exp_wr, exp_wrr, exp_wrc, exp_busy, exp_done};
         n_checks++;
         if (obs !== expv) begin
            n_fail++;
            if (n_fail <= 20)
               $display("FAIL cycle c=%0d got rd=%b(%0d,%0d) wr=%b(%0d,%0d) busy=%b done=%b required rd=%b(%0d,%0d) wr=%b(%0d,%0d) busy=%b done=%b",
                        c, rd, rd_row, rd_col, wr, wr_row, wr_col, busy, done,
                        exp_rd, exp_rr, exp_rc, exp_wr, exp_wrr, exp_wrc, exp_busy, exp_done);
         end
         if (done) done_cyc = c;
         if (rd) rd_cnt++;
         if (wr) wr_cnt++;
         if (c > 0 && m_phase == 0) begin
            tail++;
            if (tail >= 3) break;
         end
      end
      n_checks++;
      if (c >= 3 * N) begin
         n_fail++;
         $display("FAIL frame_timeout got %0d cycles required < %0d", c, 3 * N);
      end
      $display("frame: stall_e=%0d len=%0d rnd=%0d restart=%0b abort=%0d -> done_cyc=%0d rd=%0d wr=%0d",
               stall_e, stall_len, rnd_pct, restart, abort_at, done_cyc, rd_cnt, wr_cnt);
   endtask

   task automatic test_reset;
      drive_cycle(1'b0, 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({rd, wr, busy, done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_strobes got %b required 0000", {rd, wr, busy, done});
      end
      n_checks++;
      if ({rd_row, rd_col, wr_row, wr_col} !== '0) begin
         n_fail++;
         $display("FAIL reset_coords got %h required 0", {rd_row, rd_col, wr_row, wr_col});
      end
      drive_cycle(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_start_ignored got busy=%b required 0", busy);
      end
      $display("reset: rd=%b wr=%b busy=%b done=%b", rd, wr, busy, done);
   endtask

   task automatic test_frame;
      int dc, rc, wc;
      run_frame(-1, 0, 0, 1'b0, -1, dc, rc, wc);
      n_checks++;
      if (dc != N + PL + 1) begin
         n_fail++;
         $display("FAIL frame_done_cycle got %0d required %0d", dc, N + PL + 1);
      end
      n_checks++;
      if (rc != N || wc != N) begin
         n_fail++;
         $display("FAIL frame_counts got rd=%0d wr=%0d required %0d", rc, wc, N);
      end
   endtask

   task automatic test_stall_run;
      int dc, rc, wc;
      run_frame(10 * IMG_W + 20, 5, 0, 1'b0, -1, dc, rc, wc);
      n_checks++;
      if (dc != N + PL + 1 + 5) begin
         n_fail++;
         $display("FAIL stall_run_done_cycle got %0d required %0d", dc, N + PL + 6);
      end
      n_checks++;
      if (rc != N || wc != N) begin
         n_fail++;
         $display("FAIL stall_run_counts got rd=%0d wr=%0d required %0d", rc, wc, N);
      end
   endtask

   task automatic test_drain_stall;
      int dc, rc, wc;
      run_frame(N, 7, 0, 1'b0, -1, dc, rc, wc);
      n_checks++;
      if (dc != N + PL + 1 + 7) begin
         n_fail++;
         $display("FAIL drain_stall_done_cycle got %0d required %0d", dc, N + PL + 8);
      end
      n_checks++;
      if (wc != N) begin
         n_fail++;
         $display("FAIL drain_stall_wr_count got %0d required %0d", wc, N);
      end
   endtask

   task automatic test_restart_ignored;
      int dc, rc, wc;
      run_frame(-1, 0, 0, 1'b1, -1, dc, rc, wc);
      n_checks++;
      if (dc != N + PL + 1 || rc != N) begin
         n_fail++;
         $display("FAIL restart_ignored got done=%0d rd=%0d required done=%0d rd=%0d",
                  dc, rc, N + PL + 1, N);
      end
   endtask

   task automatic test_random_stall;
      int dc, rc, wc;
      run_frame(-1, 0, 25, 1'b0, -1, dc, rc, wc);
      n_checks++;
      if (rc != N || wc != N || dc < N + PL + 1) begin
         n_fail++;
         $display("FAIL random_stall got rd=%0d wr=%0d done=%0d required rd=wr=%0d done>=%0d",
                  rc, wc, dc, N, N + PL + 1);
      end
   endtask

   task automatic test_reset_midframe;
      int dc, rc, wc;
      run_frame(-1, 0, 0, 1'b0, 2000, dc, rc, wc);
      n_checks++;
      if (dc != -1 || rc != 2000) begin
         n_fail++;
         $display("FAIL abort got done=%0d rd=%0d required done=-1 rd=2000", dc, rc);
      end
      n_checks++;
      if ({rd, wr, busy, done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL abort_idle got %b required 0000", {rd, wr, busy, done});
      end
      run_frame(-1, 0, 0, 1'b0, -1, dc, rc, wc);
      n_checks++;
      if (dc != N + PL + 1 || rc != N || wc != N) begin
         n_fail++;
         $display("FAIL after_abort got done=%0d rd=%0d wr=%0d required %0d/%0d/%0d",
                  dc, rc, wc, N + PL + 1, N, N);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      stall = 1'b0;
      test_reset();
      test_frame();
      test_stall_run();
      test_drain_stall();
      test_restart_ignored();
      test_random_stall();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
